// File: rtl/irq_prio_ctrl.sv
// rtl/irq_prio_ctrl.sv - interrupt front end: sync, edge latch, mask, priority grant on valid/ack
module irq_prio_ctrl #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     irq_in,
    input  logic [N-1:0]     mask,
    input  logic             ack,
    output logic             irq_valid,
    output logic [IDX_W-1:0] irq_id,
    output logic             none_on,
    output logic [N-1:0]     pending
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } state_t;

    logic [N-1:0]     s1_q, s1_d;
    logic [N-1:0]     s2_q, s2_d;
    logic [N-1:0]     s3_q, s3_d;
    logic [N-1:0]     pending_q, pending_d;
    logic [N-1:0]     edge_det;
    logic [N-1:0]     elig;
    logic [N-1:0]     clr_mask;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] irq_id_q, irq_id_d;
    logic             irq_valid_q, irq_valid_d;
    logic             none_on_q, none_on_d;
    state_t           state_q, state_d;

    always_comb begin
        s1_d     = irq_in;
        s2_d     = s1_q;
        s3_d     = s2_q;
        edge_det = s2_q & ~s3_q;
    end

    always_comb begin
        clr_mask = '0;
        if (state_q == REQ && ack) begin
            clr_mask[irq_id_q] = 1'b1;
        end
        // A fresh edge on the bit being acknowledged must survive the clear.
        pending_d = (pending_q & ~clr_mask) | edge_det;
        elig      = pending_q & ~mask;
        none_on_d = (elig == '0);
    end

    always_comb begin
        winner = '0;
        for (int i = 0; i < N; i++) begin
            if (elig[i]) begin
                winner = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        irq_id_d    = irq_id_q;
        irq_valid_d = irq_valid_q;
        case (state_q)
            IDLE: begin
                if (elig != '0) begin
                    irq_id_d    = winner;
                    irq_valid_d = 1'b1;
                    state_d     = REQ;
                end
            end
            REQ: begin
                if (ack) begin
                    irq_valid_d = 1'b0;
                    state_d     = GAP;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                irq_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q        <= '0;
            s2_q        <= '0;
            s3_q        <= '0;
            pending_q   <= '0;
            irq_id_q    <= '0;
            irq_valid_q <= 1'b0;
            none_on_q   <= 1'b1;
            state_q     <= IDLE;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            s3_q        <= s3_d;
            pending_q   <= pending_d;
            irq_id_q    <= irq_id_d;
            irq_valid_q <= irq_valid_d;
            none_on_q   <= none_on_d;
            state_q     <= state_d;
        end
    end

    assign irq_valid = irq_valid_q;
    assign irq_id    = irq_id_q;
    assign none_on   = none_on_q;
    assign pending   = pending_q;

endmodule

// File: tb/tb_irq_prio_ctrl.sv
// tb/tb_irq_prio_ctrl.sv - directed self-checking bench for irq_prio_ctrl
module tb_irq_prio_ctrl;

    logic       clk;
    logic       rst_n;
    logic [7:0] irq_in;
    logic [7:0] mask;
    logic       ack;
    logic       irq_valid;
    logic [2:0] irq_id;
    logic       none_on;
    logic [7:0] pending;

    int n_tests;
    int n_fail;

    irq_prio_ctrl #(.N(8), .IDX_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .irq_in    (irq_in),
        .mask      (mask),
        .ack       (ack),
        .irq_valid (irq_valid),
        .irq_id    (irq_id),
        .none_on   (none_on),
        .pending   (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (irq_valid !== 1'b1 && n < 20) begin
            step(1);
            n++;
        end
        check(tag, {31'd0, irq_valid}, 32'd1);
    endtask

    task automatic do_ack();
        ack = 1'b1;
        step(1);
        ack = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        irq_in  = '0;
        mask    = '0;
        ack     = 1'b0;

        // 1: reset values
        step(3);
        check("rst_valid",   {31'd0, irq_valid}, 32'd0);
        check("rst_none_on", {31'd0, none_on},   32'd1);
        check("rst_pending", {24'd0, pending},   32'd0);
        check("rst_id",      {29'd0, irq_id},    32'd0);
        rst_n = 1'b1;
        step(2);

        // 2: single edge, latency
        irq_in = 8'h08;
        step(2);
        check("t2_pend_e1", {24'd0, pending}, 32'h00);
        step(1);
        check("t2_pend_e2",  {24'd0, pending},   32'h08);
        check("t2_valid_e2", {31'd0, irq_valid}, 32'd0);
        step(1);
        check("t2_valid_e3", {31'd0, irq_valid}, 32'd1);
        check("t2_id",       {29'd0, irq_id},    32'd3);
        check("t2_none_e3",  {31'd0, none_on},   32'd0);
        do_ack();
        check("t2_pend_ack",  {24'd0, pending},   32'h00);
        check("t2_valid_ack", {31'd0, irq_valid}, 32'd0);
        check("t2_none_ack",  {31'd0, none_on},   32'd0);
        step(1);
        check("t2_none_late", {31'd0, none_on},   32'd1);

        // 3: priority ordering
        irq_in = 8'h00;
        step(4);
        irq_in = 8'h85;
        wait_valid("t3_v7");
        check("t3_id7", {29'd0, irq_id}, 32'd7);
        check("t3_pend85", {24'd0, pending}, 32'h85);
        do_ack();
        step(1);
        check("t3_gap_valid", {31'd0, irq_valid}, 32'd0);
        step(1);
        check("t3_b2b_valid", {31'd0, irq_valid}, 32'd1);
        check("t3_id2", {29'd0, irq_id}, 32'd2);
        do_ack();
        wait_valid("t3_v0");
        check("t3_id0", {29'd0, irq_id}, 32'd0);
        do_ack();
        step(2);
        check("t3_none", {31'd0, none_on},   32'd1);
        check("t3_pend", {24'd0, pending},   32'h00);
        check("t3_idle", {31'd0, irq_valid}, 32'd0);

        // 4: mask
        irq_in = 8'h00;
        step(4);
        mask   = 8'h80;
        irq_in = 8'h81;
        wait_valid("t4_v0");
        check("t4_id0", {29'd0, irq_id}, 32'd0);
        do_ack();
        step(2);
        check("t4_pend80", {24'd0, pending},   32'h80);
        check("t4_novalid", {31'd0, irq_valid}, 32'd0);
        check("t4_none",   {31'd0, none_on},   32'd1);
        do_ack();
        step(1);
        check("t4_idle_ack", {24'd0, pending}, 32'h80);
        mask = 8'h00;
        wait_valid("t4_v7");
        check("t4_id7", {29'd0, irq_id}, 32'd7);
        mask = 8'hff;
        step(2);
        check("t4_frozen_v",  {31'd0, irq_valid}, 32'd1);
        check("t4_frozen_id", {29'd0, irq_id},    32'd7);
        mask = 8'h00;
        do_ack();
        step(2);
        check("t4_done", {24'd0, pending}, 32'h00);

        // 5: new edge on the acknowledged line in the ack clock
        irq_in = 8'h00;
        step(4);
        irq_in = 8'h08;
        wait_valid("t5_v3");
        check("t5_id3", {29'd0, irq_id}, 32'd3);
        irq_in = 8'h00;
        step(3);
        irq_in = 8'h08;
        step(2);
        check("t5_pre_pend",  {24'd0, pending},   32'h08);
        check("t5_pre_valid", {31'd0, irq_valid}, 32'd1);
        do_ack();
        check("t5_pend_kept", {24'd0, pending},   32'h08);
        check("t5_valid_low", {31'd0, irq_valid}, 32'd0);
        step(2);
        check("t5_regrant", {31'd0, irq_valid}, 32'd1);
        check("t5_id3b",    {29'd0, irq_id},    32'd3);
        do_ack();

        // 6: async reset mid-request
        irq_in = 8'h00;
        step(4);
        irq_in = 8'h10;
        wait_valid("t6_v4");
        check("t6_id4", {29'd0, irq_id}, 32'd4);
        irq_in = 8'h00;
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_valid", {31'd0, irq_valid}, 32'd0);
        check("t6_async_pend",  {24'd0, pending},   32'h00);
        check("t6_async_none",  {31'd0, none_on},   32'd1);
        step(2);
        rst_n = 1'b1;
        step(6);
        check("t6_no_grant", {31'd0, irq_valid}, 32'd0);
        check("t6_none",     {31'd0, none_on},   32'd1);
        irq_in = 8'h10;
        wait_valid("t6_fresh");
        check("t6_id4b", {29'd0, irq_id}, 32'd4);
        do_ack();
        step(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
